// File: rtl/slave_mem.sv
// Word-addressed 32-bit memory slave behind a crossbar port: ack one cycle after req, resp LATENCY cycles later.
// Optional macro SLAVE_MEM_WR_RESP_EN gives writes the same resp timing as reads; without it writes finish after ack.
module slave_mem #(
  parameter int ADDR_W  = 30,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              cmd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ack,
  output logic              resp,
  output logic [31:0]       rdata,
  output logic              overrun
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

`ifdef SLAVE_MEM_WR_RESP_EN
  localparam bit WR_RESP = 1'b1;
`else
  localparam bit WR_RESP = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               cmd_q;
  logic [IDX_W-1:0]   idx_q;
  logic               ack_q;
  logic               resp_q;
  logic               overrun_q;
  logic [31:0]        rdata_q;

  logic [31:0]        mem [DEPTH];

  logic [IDX_W-1:0]   req_idx;
  logic               accept;
  logic               mem_we;

  assign req_idx = addr[IDX_W-1:0];
  assign accept  = (state_q == IDLE) && req;
  // Reset wins over a coincident request, so the write is suppressed too.
  assign mem_we  = accept && cmd && !rst;

  generate
    if (ADDR_W > IDX_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[ADDR_W-1:IDX_W];
    end
  endgenerate

  // Memory array carries no reset so it maps onto block RAM and keeps contents across rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[req_idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cmd_q     <= 1'b0;
      idx_q     <= '0;
      ack_q     <= 1'b0;
      resp_q    <= 1'b0;
      rdata_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      resp_q <= 1'b0;
      if (req && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (req) begin
            cmd_q   <= cmd;
            idx_q   <= req_idx;
            ack_q   <= 1'b1;
            state_q <= ACK;
          end
        end
        ACK: begin
          if (!cmd_q || WR_RESP) begin
            if (LATENCY > 1) begin
              cnt_q   <= CNT_W'(LATENCY - 1);
              state_q <= WAIT;
            end else begin
              resp_q  <= 1'b1;
              rdata_q <= mem[idx_q];
              state_q <= RESP;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            resp_q  <= 1'b1;
            rdata_q <= mem[idx_q];
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack     = ack_q;
  assign resp    = resp_q;
  assign rdata   = rdata_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_slave_mem.sv
// Self-checking bench for slave_mem (DEPTH=16, LATENCY=3): random traffic against an array model with arithmetic timing.
module tb_slave_mem;

  localparam int ADDR_W  = 30;
  localparam int DEPTH   = 16;
  localparam int LATENCY = 3;

`ifdef SLAVE_MEM_WR_RESP_EN
  localparam bit WR_RESP = 1'b1;
`else
  localparam bit WR_RESP = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              req;
  logic              cmd;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ack;
  logic              resp;
  logic [31:0]       rdata;
  logic              overrun;

  slave_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .cmd    (cmd),
    .addr   (addr),
    .wdata  (wdata),
    .ack    (ack),
    .resp   (resp),
    .rdata  (rdata),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          txn_no = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_rdata;
  logic        exp_overrun;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input bit e_ack, input bit e_resp);
    check({tag, ".ack"},     {31'b0, ack},     {31'b0, e_ack});
    check({tag, ".resp"},    {31'b0, resp},    {31'b0, e_resp});
    check({tag, ".rdata"},   rdata,            exp_rdata);
    check({tag, ".overrun"}, {31'b0, overrun}, {31'b0, exp_overrun});
  endtask

  // One request; ack expected at offset 1, resp at offset 1+LATENCY (reads, or writes with wr-resp).
  // inject>0 pulses a stray request at that offset, which must be ignored and flag overrun.
  task automatic txn(input bit c, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                     input int inject, input bit no_wait);
    int          idx;
    int          n;
    bit          pend;
    logic [31:0] resp_val;
    if (!no_wait) @(negedge clk);
    check_outputs("idle", 1'b0, 1'b0);
    req   = 1'b1;
    cmd   = c;
    addr  = a;
    wdata = d;
    idx   = int'(a) % DEPTH;
    if (c) model_mem[idx] = d;
    resp_val = model_mem[idx];
    n    = (c && !WR_RESP) ? 1 : 1 + LATENCY;
    pend = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (pend) begin
        exp_overrun = 1'b1;
        pend        = 1'b0;
      end
      if (i == n && n > 1) exp_rdata = resp_val;
      check_outputs(c ? "wr" : "rd", i == 1, (i == n) && (n > 1));
      if (i == inject && i < n) begin
        req   = 1'b1;
        cmd   = 1'($urandom);
        addr  = ADDR_W'($urandom);
        wdata = $urandom;
        pend  = 1'b1;
      end
    end
    txn_no++;
    $display("txn %0d: %s addr=0x%h data=0x%h stray_at=%0d overrun=%0d", txn_no, c ? "WR" : "RD",
             a, c ? d : resp_val, inject, overrun);
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      check_outputs("gap", 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst         = 1'b1;
    req         = 1'b0;
    cmd         = 1'b0;
    addr        = '0;
    wdata       = '0;
    exp_rdata   = '0;
    exp_overrun = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_outputs("reset", 1'b0, 1'b0);

    // Fill every index so later reads never hit uninitialised words.
    for (int i = 0; i < DEPTH; i++) begin
      txn(1'b1, {ADDR_W'($urandom) >> 4, 4'(i)}, $urandom, 0, 1'b0);
    end

    // Directed: write then immediate read, and index aliasing through upper bits.
    txn(1'b1, 30'h5, 32'hDEAD_BEEF, 0, 1'b0);
    txn(1'b0, 30'h5, 32'h0, 0, 1'b0);
    txn(1'b1, 30'h5, 32'h1234_5678, 0, 1'b0);
    txn(1'b0, 30'h15, 32'h0, 0, 1'b0);

    // Random traffic with occasional idle gaps and stray requests while busy.
    for (int i = 0; i < 60; i++) begin
      int inj;
      inj = ($urandom_range(0, 3) == 0) ? $urandom_range(1, LATENCY) : 0;
      txn(1'($urandom), ADDR_W'($urandom), $urandom, inj, 1'b0);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
    end
    // Guarantee at least one stray request has been seen before the reset tests.
    txn(1'b0, 30'h3, 32'h0, 2, 1'b0);

    // Reset mid-transaction: ack seen, resp never delivered, new req accepted right after.
    @(negedge clk);
    check_outputs("abort.idle", 1'b0, 1'b0);
    req  = 1'b1;
    cmd  = 1'b0;
    addr = 30'h7;
    @(negedge clk);
    req = 1'b0;
    check_outputs("abort.ack", 1'b1, 1'b0);
    @(negedge clk);
    check_outputs("abort.wait", 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    exp_rdata   = '0;
    exp_overrun = 1'b0;
    check_outputs("abort.rst", 1'b0, 1'b0);
    txn(1'b0, 30'h9, 32'h0, 0, 1'b1);

    // Reset coincident with a write request: the write must be dropped.
    @(negedge clk);
    req   = 1'b1;
    cmd   = 1'b1;
    addr  = 30'h2;
    wdata = ~model_mem[2];
    rst   = 1'b1;
    @(negedge clk);
    req       = 1'b0;
    rst       = 1'b0;
    exp_rdata = '0;
    check_outputs("rstreq", 1'b0, 1'b0);
    txn(1'b0, 30'h2, 32'h0, 0, 1'b0);

    // Contents written before reset persist.
    for (int i = 0; i < 4; i++) begin
      txn(1'b0, ADDR_W'($urandom), 32'h0, 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
